// File: rtl/bcd_updown_counter_n.sv
// N-digit cascaded BCD up/down counter with tick prescaler, parallel load and wrap/saturate limits.
// Count and all flags are registered; Tick, Wrap, AtMax and AtMin are valid together with the new Count.
module bcd_updown_counter_n #(
  parameter int DIGITS   = 3,
  parameter int TICK_DIV = 5000000,
  parameter int SATURATE = 0
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Enable,
  input  logic                  Up,
  input  logic                  Preset,
  input  logic                  Load,
  input  logic [4*DIGITS-1:0]   LoadValue,
  output logic [4*DIGITS-1:0]   Count,
  output logic                  Tick,
  output logic                  Wrap,
  output logic                  AtMax,
  output logic                  AtMin
);

  localparam int W  = 4 * DIGITS;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PMAX  = PW'(TICK_DIV - 1);
  localparam logic [W-1:0]  NINES = {DIGITS{4'h9}};

  logic [PW-1:0] presc_q, presc_d;
  logic [W-1:0]  count_q, count_d;
  logic          tick_q, tick_d;
  logic          wrap_q, wrap_d;
  logic          at_max_q, at_max_d;
  logic          at_min_q, at_min_d;

  logic          step;
  logic [W-1:0]  inc_v, dec_v, load_v;
  logic          all9, all0, carry, borrow;
  logic [3:0]    dig, ld_dig;

  always_comb begin
    step    = Enable && (presc_q == PMAX);
    presc_d = presc_q;
    if (Enable) presc_d = step ? '0 : presc_q + 1'b1;
  end

  // Ripple carry/borrow across decades; a digit moves only while every lower digit is at its limit.
  always_comb begin
    inc_v  = count_q;
    dec_v  = count_q;
    load_v = '0;
    all9   = 1'b1;
    all0   = 1'b1;
    carry  = 1'b1;
    borrow = 1'b1;
    dig    = '0;
    ld_dig = '0;
    for (int i = 0; i < DIGITS; i++) begin
      dig = count_q[4*i +: 4];
      if (dig != 4'd9) all9 = 1'b0;
      if (dig != 4'd0) all0 = 1'b0;
      if (carry) begin
        if (dig == 4'd9) begin
          inc_v[4*i +: 4] = 4'd0;
        end else begin
          inc_v[4*i +: 4] = dig + 4'd1;
          carry = 1'b0;
        end
      end
      if (borrow) begin
        if (dig == 4'd0) begin
          dec_v[4*i +: 4] = 4'd9;
        end else begin
          dec_v[4*i +: 4] = dig - 4'd1;
          borrow = 1'b0;
        end
      end
      ld_dig = LoadValue[4*i +: 4];
      load_v[4*i +: 4] = (ld_dig > 4'd9) ? 4'd9 : ld_dig;
    end
  end

  always_comb begin
    count_d = count_q;
    tick_d  = 1'b0;
    wrap_d  = 1'b0;
    if (Load) begin
      count_d = load_v;
    end else if (Preset) begin
      count_d = NINES;
    end else if (step) begin
      tick_d = 1'b1;
      if (Up) begin
        if (all9) begin
          wrap_d  = 1'b1;
          count_d = (SATURATE != 0) ? count_q : '0;
        end else begin
          count_d = inc_v;
        end
      end else begin
        if (all0) begin
          wrap_d  = 1'b1;
          count_d = (SATURATE != 0) ? count_q : NINES;
        end else begin
          count_d = dec_v;
        end
      end
    end
    at_max_d = (count_d == NINES);
    at_min_d = (count_d == '0);
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      presc_q  <= '0;
      count_q  <= '0;
      tick_q   <= 1'b0;
      wrap_q   <= 1'b0;
      at_max_q <= 1'b0;
      at_min_q <= 1'b1;
    end else begin
      presc_q  <= presc_d;
      count_q  <= count_d;
      tick_q   <= tick_d;
      wrap_q   <= wrap_d;
      at_max_q <= at_max_d;
      at_min_q <= at_min_d;
    end
  end

  assign Count = count_q;
  assign Tick  = tick_q;
  assign Wrap  = wrap_q;
  assign AtMax = at_max_q;
  assign AtMin = at_min_q;

endmodule

// File: tb/tb_bcd_updown_counter_n.sv
// Bench for bcd_updown_counter_n: wrap and saturate instances driven in parallel against an
// integer-valued reference model, plus directed scenarios with literal expectations.
module tb_bcd_updown_counter_n;

  localparam int D  = 3;
  localparam int TD = 4;

  logic        Clock = 1'b0;
  logic        Reset, Enable, Up, Preset, Load;
  logic [11:0] LoadValue;
  logic [11:0] cnt0, cnt1;
  logic        tk0, tk1, wr0, wr1, mx0, mx1, mn0, mn1;

  int checks   = 0;
  int failures = 0;

  int mval [2];
  int mpres;
  bit mtick [2];
  bit mwrap [2];

  always #5 Clock = ~Clock;

  bcd_updown_counter_n #(.DIGITS(D), .TICK_DIV(TD), .SATURATE(0)) u_wrap (
    .Clock(Clock), .Reset(Reset), .Enable(Enable), .Up(Up), .Preset(Preset), .Load(Load),
    .LoadValue(LoadValue), .Count(cnt0), .Tick(tk0), .Wrap(wr0), .AtMax(mx0), .AtMin(mn0));

  bcd_updown_counter_n #(.DIGITS(D), .TICK_DIV(TD), .SATURATE(1)) u_sat (
    .Clock(Clock), .Reset(Reset), .Enable(Enable), .Up(Up), .Preset(Preset), .Load(Load),
    .LoadValue(LoadValue), .Count(cnt1), .Tick(tk1), .Wrap(wr1), .AtMax(mx1), .AtMin(mn1));

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic int clamp_val(input logic [11:0] v);
    int r = 0;
    int m = 1;
    int d;
    for (int i = 0; i < 3; i++) begin
      d = int'(v[4*i +: 4]);
      if (d > 9) d = 9;
      r += d * m;
      m *= 10;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mpres = 0;
    for (int k = 0; k < 2; k++) begin
      mval[k] = 0; mtick[k] = 0; mwrap[k] = 0;
    end
  endtask

  task automatic model_edge();
    bit s;
    s = Enable && (mpres == TD - 1);
    if (Enable) mpres = s ? 0 : mpres + 1;
    for (int k = 0; k < 2; k++) begin
      mtick[k] = 0; mwrap[k] = 0;
      if (Load) mval[k] = clamp_val(LoadValue);
      else if (Preset) mval[k] = 999;
      else if (s) begin
        mtick[k] = 1;
        if (Up) begin
          if (mval[k] == 999) begin mwrap[k] = 1; mval[k] = (k == 1) ? 999 : 0; end
          else mval[k] = mval[k] + 1;
        end else begin
          if (mval[k] == 0) begin mwrap[k] = 1; mval[k] = (k == 1) ? 0 : 999; end
          else mval[k] = mval[k] - 1;
        end
      end
    end
  endtask

  task automatic compare_all();
    chk("count_wrap", cnt0, to_bcd(mval[0]));
    chk("tick_wrap",  tk0,  mtick[0]);
    chk("wrapf_wrap", wr0,  mwrap[0]);
    chk("atmax_wrap", mx0,  mval[0] == 999);
    chk("atmin_wrap", mn0,  mval[0] == 0);
    chk("count_sat",  cnt1, to_bcd(mval[1]));
    chk("tick_sat",   tk1,  mtick[1]);
    chk("wrapf_sat",  wr1,  mwrap[1]);
    chk("atmax_sat",  mx1,  mval[1] == 999);
    chk("atmin_sat",  mn1,  mval[1] == 0);
  endtask

  task automatic cycle();
    @(posedge Clock);
    model_edge();
    @(negedge Clock);
    compare_all();
  endtask

  task automatic set_in(input bit en, input bit up, input bit pre, input bit ld, input logic [11:0] lv);
    Enable = en; Up = up; Preset = pre; Load = ld; LoadValue = lv;
  endtask

  task automatic run_to_tick(input int bound, output int n);
    n = 0;
    do begin
      cycle();
      n++;
    end while (!mtick[0] && n < bound);
    if (!mtick[0]) chk("tick_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_to_pres(input int target);
    int n = 0;
    while (mpres != target && n < 2 * TD) begin
      cycle();
      n++;
    end
    if (mpres != target) chk("pres_timeout", 32'(mpres), 32'(target));
  endtask

  initial begin
    int n, ticks;
    logic [11:0] frozen;

    set_in(0, 0, 0, 0, 12'h000);
    Reset = 1'b1;
    @(negedge Clock);
    @(negedge Clock);
    model_reset();
    compare_all();
    chk("reset_count_lit", cnt0, 12'h000);
    chk("reset_atmin_lit", mn0, 1'b1);
    Reset = 1'b0;

    // Free count up: one step every TD cycles.
    set_in(1, 1, 0, 0, 12'h000);
    ticks = 0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (tk0) ticks++;
      if (i == 3) chk("first_step_lit", cnt0, 12'h001);
    end
    chk("count_12cyc_lit", cnt0, 12'h003);
    chk("tick_pulses_lit", 32'(ticks), 32'd3);

    set_in(1, 1, 0, 1, 12'h099);
    cycle();
    Load = 1'b0;
    run_to_tick(2 * TD, n);
    chk("carry_lit", cnt0, 12'h100);
    chk("carry_nowrap_lit", wr0, 1'b0);

    set_in(1, 1, 1, 0, 12'h000);
    cycle();
    Preset = 1'b0;
    run_to_tick(2 * TD, n);
    chk("wrap_up_lit", cnt0, 12'h000);
    chk("wrap_up_flag_lit", wr0, 1'b1);
    chk("wrap_up_atmin_lit", mn0, 1'b1);
    Up = 1'b0;
    run_to_tick(2 * TD, n);
    chk("wrap_dn_lit", cnt0, 12'h999);
    chk("wrap_dn_flag_lit", wr0, 1'b1);
    chk("wrap_dn_atmax_lit", mx0, 1'b1);

    set_in(1, 0, 0, 1, 12'h000);
    cycle();
    Load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      run_to_tick(2 * TD, n);
      chk("sat_hold_lit", cnt1, 12'h000);
      chk("sat_wrap_lit", wr1, 1'b1);
      chk("sat_tick_lit", tk1, 1'b1);
    end

    set_in(1, 1, 0, 1, 12'hA5F);
    cycle();
    chk("clamp_lit", cnt0, 12'h959);
    Load = 1'b0;

    run_to_pres(TD - 1);
    set_in(1, 1, 0, 1, 12'h123);
    cycle();
    chk("load_on_s_lit", cnt0, 12'h123);
    chk("load_on_s_tick_lit", tk0, 1'b0);
    Load = 1'b0;

    run_to_pres(1);
    frozen = to_bcd(mval[0]);
    Enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("frozen_count", cnt0, frozen);
    end
    Enable = 1'b1;
    run_to_tick(2 * TD, n);
    chk("resume_latency_lit", 32'(n), 32'd3);

    for (int i = 0; i < 400; i++) begin
      set_in($urandom_range(0, 9) < 8, $urandom_range(0, 1) == 1, $urandom_range(0, 19) == 0,
             $urandom_range(0, 19) == 0, 12'($urandom));
      cycle();
    end

    set_in(1, 1, 0, 1, 12'h456);
    cycle();
    Load = 1'b0;
    run_to_pres(2);
    @(posedge Clock);
    model_edge();
    #2 Reset = 1'b1;
    #1;
    chk("async_count_lit", cnt0, 12'h000);
    chk("async_atmin_lit", mn0, 1'b1);
    chk("async_count_sat_lit", cnt1, 12'h000);
    model_reset();
    @(negedge Clock);
    compare_all();
    Reset = 1'b0;
    for (int i = 0; i < 2 * TD; i++) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
